// File: rtl/alu_seq.sv
// alu_seq: handshaked execute unit, 1-cycle integer ops, iterative RV32M.
// Define ALU_SEQ_MULDIV_EN to build the multiply/divide FSM and datapath.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_EQ   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_NE   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_GE   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_GEU  = OP_W'(13);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res;
  logic             accept;
  logic             drain;

  assign shamt     = b[SH_W-1:0];
  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_NE:   alu_res = {{(WIDTH-1){1'b0}}, a != b};
      OP_GE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) >= $signed(b)};
      OP_GEU:  alu_res = {{(WIDTH-1){1'b0}}, a >= b};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(16);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(17);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(18);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(20);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(22);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(23);

  logic             busy_q, busy_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic             hi_q, hi_d;

  logic             is_mul, is_div;
  logic             a_sgn, b_sgn, op_rem;
  logic             a_neg, b_neg;
  logic             by_zero, ovf;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_nxt, fix_p;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [PW-1:0]    div_nxt;
  logic [WIDTH-1:0] div_v, div_fix;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    op_rem = 1'b0;
    case (op)
      OP_MUL:    is_mul = 1'b1;
      OP_MULH:   begin is_mul = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
      OP_MULHSU: begin is_mul = 1'b1; a_sgn = 1'b1; end
      OP_MULHU:  is_mul = 1'b1;
      OP_DIV:    begin is_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
      OP_DIVU:   is_div = 1'b1;
      OP_REM: begin
        is_div = 1'b1;
        a_sgn  = 1'b1;
        b_sgn  = 1'b1;
        op_rem = 1'b1;
      end
      OP_REMU:   begin is_div = 1'b1; op_rem = 1'b1; end
      default:   is_mul = 1'b0;
    endcase
  end

  assign a_neg   = a_sgn && a[WIDTH-1];
  assign b_neg   = b_sgn && b[WIDTH-1];
  assign abs_a   = a_neg ? -a : a;
  assign abs_b   = b_neg ? -b : b;
  assign by_zero = (b == '0);
  assign ovf     = a_sgn && (a == MIN) && (&b);

  // prod_q: {acc, multiplier} for MUL, {remainder, dividend} for DIV
  assign mul_sum = {1'b0, prod_q[PW-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_nxt = {mul_sum, prod_q[WIDTH-1:1]};
  assign fix_p   = neg_q ? -mul_nxt : mul_nxt;

  assign div_sh  = prod_q[PW-1:WIDTH-1];
  assign div_ge  = div_sh >= {1'b0, mcand_q};
  assign div_sub = div_sh[WIDTH-1:0] - mcand_q;
  assign div_nxt = {div_ge ? div_sub : div_sh[WIDTH-1:0],
                    prod_q[WIDTH-2:0], div_ge};
  assign div_v   = hi_q ? div_nxt[PW-1:WIDTH] : div_nxt[WIDTH-1:0];
  assign div_fix = neg_q ? -div_v : div_v;

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
`ifdef ALU_SEQ_MULDIV_EN
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
`endif
    if (drain) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          result_d    = alu_res;
`ifdef ALU_SEQ_MULDIV_EN
          if (is_mul) begin
            out_valid_d = 1'b0;
            state_d     = S_MUL;
            busy_d      = 1'b1;
            cnt_d       = SH_W'(WIDTH - 1);
            prod_d      = {{WIDTH{1'b0}}, abs_b};
            mcand_d     = abs_a;
            neg_d       = a_neg ^ b_neg;
            hi_d        = (op != OP_MUL);
          end else if (is_div) begin
            if (by_zero) begin
              result_d = op_rem ? a : '1;
            end else if (ovf) begin
              result_d = op_rem ? '0 : MIN;
            end else begin
              out_valid_d = 1'b0;
              state_d     = S_DIV;
              busy_d      = 1'b1;
              cnt_d       = SH_W'(WIDTH - 1);
              prod_d      = {{WIDTH{1'b0}}, abs_a};
              mcand_d     = abs_b;
              neg_d       = op_rem ? a_neg : (a_neg ^ b_neg);
              hi_d        = op_rem;
            end
          end
`endif
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_MUL: begin
        prod_d = mul_nxt;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          result_d    = hi_q ? fix_p[PW-1:WIDTH] : fix_p[WIDTH-1:0];
        end
      end
      S_DIV: begin
        prod_d = div_nxt;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          result_d    = div_fix;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
`ifdef ALU_SEQ_MULDIV_EN
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32).
// Expected values come from literals or a 64-bit reference model.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  logic [31:0] sb[$];
  logic [31:0] cur_exp = '0;
  bit          acc_seen = 1'b0;
  bit          rand_rdy = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_stray = 0;
  int          cyc = 0;

`ifdef ALU_SEQ_MULDIV_EN
  localparam int LAT_M = 33;
  localparam bit MD = 1'b1;
`else
  localparam int LAT_M = 1;
  localparam bit MD = 1'b0;
`endif

  localparam logic [4:0] O_ADD = 5'd0, O_SUB = 5'd1, O_SLL = 5'd2;
  localparam logic [4:0] O_SLT = 5'd3, O_SLTU = 5'd4, O_XOR = 5'd5;
  localparam logic [4:0] O_SRL = 5'd6, O_SRA = 5'd7, O_OR = 5'd8;
  localparam logic [4:0] O_AND = 5'd9, O_EQ = 5'd10, O_NE = 5'd11;
  localparam logic [4:0] O_GE = 5'd12, O_GEU = 5'd13;
  localparam logic [4:0] O_MUL = 5'd16, O_MULH = 5'd17;
  localparam logic [4:0] O_MULHU = 5'd19, O_DIV = 5'd20;
  localparam logic [4:0] O_DIVU = 5'd21, O_REM = 5'd22, O_REMU = 5'd23;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .OP_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [4:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    logic [31:0] r;
    logic [63:0] p;
    logic [4:0]  sh;
    logic        ov;
    sh = y[4:0];
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r  = '0;
    p  = '0;
    case (o)
      5'd0:  r = x + y;
      5'd1:  r = x - y;
      5'd2:  r = x << sh;
      5'd3:  r = {31'd0, $signed(x) < $signed(y)};
      5'd4:  r = {31'd0, x < y};
      5'd5:  r = x ^ y;
      5'd6:  r = x >> sh;
      5'd7:  r = $signed(x) >>> sh;
      5'd8:  r = x | y;
      5'd9:  r = x & y;
      5'd10: r = {31'd0, x == y};
      5'd11: r = {31'd0, x != y};
      5'd12: r = {31'd0, $signed(x) >= $signed(y)};
      5'd13: r = {31'd0, x >= y};
`ifdef ALU_SEQ_MULDIV_EN
      5'd16: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; end
      5'd17: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        r = p[63:32];
      end
      5'd18: begin
        p = $signed({{32{x[31]}}, x}) * $signed({32'd0, y});
        r = p[63:32];
      end
      5'd19: begin p = {32'd0, x} * {32'd0, y}; r = p[63:32]; end
      5'd20: begin
        if (y == '0) r = '1;
        else if (ov) r = x;
        else r = $signed(x) / $signed(y);
      end
      5'd21: begin
        if (y == '0) r = '1;
        else r = x / y;
      end
      5'd22: begin
        if (y == '0) r = x;
        else if (ov) r = '0;
        else r = $signed(x) % $signed(y);
      end
      5'd23: begin
        if (y == '0) r = x;
        else r = x % y;
      end
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd7;
      default: return $urandom();
    endcase
  endfunction

  // One cycle: sample handshakes 1ns before the edge, return at negedge
  task automatic step();
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    #4;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) n_stray++;
      else check("result", result, sb.pop_front());
    end
    acc_seen = rst && in_valid && in_ready;
    if (acc_seen) sb.push_back(cur_exp);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [4:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] e);
    int t;
    t = 0;
    op = o;
    a = x;
    b = y;
    cur_exp = e;
    in_valid = 1'b1;
    do begin
      step();
      t++;
    end while (!acc_seen && t < 300);
    in_valid = 1'b0;
    check("accept", 32'(acc_seen), 32'd1);
  endtask

  task automatic wait_out(input string tag, input int lat);
    int n;
    bit bok;
    n = 1;
    bok = 1'b1;
    while (!out_valid && n < 200) begin
      if (!busy) bok = 1'b0;
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    if (lat > 1) check({tag, "_busy"}, 32'(bok), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int c0;
    int t;
    logic [4:0]  ro;
    logic [31:0] rx, ry;

    @(negedge clk);
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    out_ready = 1'b1;

    send(O_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_now", result, 32'd0);
    send(O_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000);
    send(O_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    send(O_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    send(O_SLL, 32'd1, 32'h23, 32'd8);
    send(O_SRL, 32'h8000_0000, 32'd31, 32'd1);
    c0 = cyc;
    send(O_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    send(O_OR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    send(O_AND, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000);
    send(O_EQ, 32'd9, 32'd9, 32'd1);
    check("b2b_cycles", 32'(cyc - c0), 32'd4);
    send(O_NE, 32'd9, 32'd9, 32'd0);
    send(O_GE, 32'h8000_0000, 32'd0, 32'd0);
    send(O_GEU, 32'h8000_0000, 32'd0, 32'd1);
    send(5'd14, 32'd3, 32'd4, 32'd0);
    send(5'd31, 32'd3, 32'd4, 32'd0);
    step();

    out_ready = 1'b0;
    send(O_ADD, 32'd2, 32'd3, 32'd5);
    repeat (3) begin
      check("hold_res", result, 32'd5);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    send(O_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    check("sub_valid", 32'(out_valid), 32'd1);
    step();

    send(O_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);
    wait_out("mul", LAT_M);
    step();
    send(O_MULHU, 32'h0001_0000, 32'h0001_0000, MD ? 32'd1 : 32'd0);
    wait_out("mulhu", LAT_M);
    step();
    send(O_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    wait_out("mulh", LAT_M);
    step();
    send(O_DIV, 32'hFFFF_FFF9, 32'd2, MD ? 32'hFFFF_FFFD : 32'd0);
    wait_out("div", LAT_M);
    step();
    send(O_REM, 32'hFFFF_FFF9, 32'd2, MD ? 32'hFFFF_FFFF : 32'd0);
    wait_out("rem", LAT_M);
    step();
    send(O_DIVU, 32'd7, 32'd0, MD ? 32'hFFFF_FFFF : 32'd0);
    wait_out("divz", 1);
    step();
    send(O_REMU, 32'd7, 32'd0, MD ? 32'd7 : 32'd0);
    wait_out("remz", 1);
    step();
    send(O_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
         MD ? 32'h8000_0000 : 32'd0);
    wait_out("ovf", 1);
    step();
    send(O_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    wait_out("ovfr", 1);
    step();

    rand_rdy = 1'b1;
    repeat (40) begin
      ro = 5'($urandom_range(0, 31));
      rx = pick();
      ry = pick();
      send(ro, rx, ry, model(ro, rx, ry));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      step();
      t++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    step();

    out_ready = 1'b0;
    send(O_DIV, 32'd100, 32'd7, MD ? 32'd14 : 32'd0);
    repeat (10) step();
    rst = 1'b0;
    step();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_result", result, 32'd0);
    sb.delete();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (40) step();
    check("no_stray", 32'(n_stray), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
